sd_spi_responder: RTL and testbench
===================================

SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flops in each input synchroniser for SCLK, MOSI and nSDCS; legal values 2 and 3.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'hFF: byte shifted out on MISO when no response byte is queued.
REQ-003 SHALL have port CLKX4, input, 1 bit: the single clock. All logic is clocked on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port SCLK, input, 1 bit: SPI clock from the MMU SD master; asynchronous to CLKX4.
REQ-006 SHALL have port MOSI, input, 1 bit: serial data from the master.
REQ-007 SHALL have port nSDCS, input, 1 bit: active-low card select.
REQ-008 SHALL have port MISO, output, 1 bit: serial data to the master.
REQ-009 SHALL have port MISO_OE, output, 1 bit: MISO drive enable; the top level tri-states MISO when this is low.
REQ-010 SHALL have port RX_DATA, output, 8 bits: last complete byte received.
REQ-011 SHALL have port RX_STROBE, output, 1 bit: one-cycle pulse when RX_DATA updates.
REQ-012 SHALL have the following command-frame ports:
- CMD_VALID, output, 1 bit: decoded frame held.
- CMD_INDEX, output, 6 bits: command index.
- CMD_ARG, output, 32 bits: argument.
- CMD_CRC, output, 7 bits: CRC7 field.
- CMD_ACK, input, 1 bit: consumer releases the held frame.
REQ-013 SHALL have the following response and status ports:
- RSP_DATA, input, 8 bits: response byte.
- RSP_VALID, input, 1 bit: response byte offered.
- RSP_READY, output, 1 bit: holding register empty.
- FRAME_ERR, output, 1 bit: one-cycle pulse on a bad stop bit.
- OVERRUN, output, 1 bit: one-cycle pulse when a frame is dropped while CMD_VALID is high.

Function
REQ-014 SHALL synchronise SCLK, MOSI and nSDCS through SYNC_STAGES flops, then detect SCLK rise and fall as edges between consecutive synchronised samples.
REQ-015 SHALL operate in SPI mode 0 and SHALL be correct for SCLK period >= 8 CLKX4 periods, with each high and low phase >= 4 CLKX4 periods.
REQ-016 SHALL, on each synchronised SCLK rise while nSDCS is low, shift the synchronised MOSI into the receive register MSB-first and increment a 3-bit bit counter.
REQ-017 SHALL, on the 8th rise (counter wraps 7 to 0), load RX_DATA and pulse RX_STROBE one cycle after that rise is detected.
REQ-018 SHALL, while nSDCS is high, hold the bit counter at 0 and discard any partial byte.
REQ-019 SHALL run the frame state machine with states HUNT, COLLECT and PENDING:
- HUNT: a byte with bits[7:6]=2'b01 moves to COLLECT with byte count 1.
- COLLECT: after byte 6, move to PENDING if bit0=1; otherwise pulse FRAME_ERR and return to HUNT.
- PENDING: CMD_VALID=1; CMD_ACK moves to HUNT in the next cycle.
REQ-020 SHALL capture frame fields as: CMD_INDEX = byte1[5:0]; CMD_ARG = {byte2, byte3, byte4, byte5}; CMD_CRC = byte6[7:1].
REQ-021 SHALL hold CMD_INDEX, CMD_ARG and CMD_CRC stable while CMD_VALID is high.
REQ-022 SHALL ignore received bytes in PENDING for framing purposes.
REQ-023 SHALL pulse OVERRUN once per start byte (bits[7:6]=01) received while in PENDING.
REQ-024 SHALL return COLLECT to HUNT, without raising FRAME_ERR, when nSDCS deasserts mid-frame.
REQ-025 SHALL provide a single-entry response holding register: RSP_READY=1 when it is empty; RSP_VALID and RSP_READY both high in one cycle loads RSP_DATA.
REQ-026 SHALL, at each byte boundary (8th rise) and at synchronised nSDCS assertion, load the transmit shift register from the holding register if full (emptying it), else from IDLE_BYTE.
REQ-027 SHALL drive MISO from transmit shift register bit 7, shift it left on each synchronised SCLK fall while nSDCS is low, and fill the vacated bit with 1.
REQ-028 SHALL set MISO_OE equal to the inverted synchronised nSDCS, and drive MISO=1 while MISO_OE is low.
REQ-029 SHALL, when a byte boundary and a holding-register load occur in the same cycle, perform the shift-register load from the old holding contents first; the new byte then occupies the holding register.
REQ-030 SHALL, when CMD_ACK and a completing 6th byte coincide in PENDING, give CMD_ACK priority: the new frame is dropped and OVERRUN is not pulsed.

Reset
REQ-031 SHALL, while RESET is high, put the state machine in HUNT and clear the bit and byte counters.
REQ-032 SHALL reset the following outputs: CMD_VALID=0, RX_STROBE=0, FRAME_ERR=0, OVERRUN=0, RSP_READY=1, MISO=1, MISO_OE=0.
REQ-033 SHALL reset data registers as: RX_DATA=0, CMD fields=0, transmit shift register=IDLE_BYTE, synchronisers=idle (SCLK 0, nSDCS 1).
REQ-034 SHALL, when RESET is asserted mid-frame, abandon the frame; after release, no frame completes until a new start byte is received.

Structure
REQ-035 SHALL place the state enum (HUNT, COLLECT, PENDING), FRAME_BYTES=6 and START_PATTERN=2'b01 in shared package spi_sd_pkg.
REQ-036 SHALL implement the synchroniser as one sub-module, spi_sync, parameterised by SYNC_STAGES and instantiated three times.

Verification
REQ-037 SHALL cover: CMD0 frame 40 00 00 00 00 95 -> CMD_VALID=1, INDEX=0, ARG=0, CRC=7'h4A; CMD_ACK -> CMD_VALID=0 the next cycle.
REQ-038 SHALL cover: CMD17 frame 51 00 00 02 00 FF, RSP_DATA=8'h00 loaded during byte 6 -> MISO returns 00 in byte 7, then FF in byte 8.
REQ-039 SHALL cover: frame 48 00 00 01 AA 86 (stop bit 0) -> FRAME_ERR pulses once, CMD_VALID stays 0, next valid frame accepted.
REQ-040 SHALL cover: nSDCS deasserted after 3 bytes of 4C xx xx -> state HUNT, no FRAME_ERR; following frame 40 00 00 00 00 95 decodes correctly.
REQ-041 SHALL cover: second complete frame sent while PENDING -> OVERRUN pulses once and the first frame's fields remain unchanged.
REQ-042 SHALL cover: RESET asserted after 4 frame bytes -> all outputs at reset values; trailing 2 bytes produce no CMD_VALID.

Source files
------------

// File: rtl/spi_sd_pkg.sv
// spi_sd_pkg: shared frame-decoder types and constants for sd_spi_responder
package spi_sd_pkg;
    typedef enum logic [1:0] {HUNT, COLLECT, PENDING} frame_state_t;
    localparam int FRAME_BYTES = 6;
    localparam logic [1:0] START_PATTERN = 2'b01;
    function automatic logic is_start(input logic [7:0] b);
        return b[7:6] == START_PATTERN;
    endfunction
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchroniser for one asynchronous input bit
// i_clk/i_rst: sampling clock and sync active-high reset (loads RST_VAL)
// i_d: asynchronous input; o_q: synchronised output
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sh;
    always_ff @(posedge i_clk)
        r_sh <= i_rst ? {STAGES{RST_VAL}} : {r_sh[STAGES-2:0], i_d};
    assign o_q = r_sh[STAGES-1];
endmodule

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI mode-0 SD-card responder with command-frame decoder
// CLKX4/RESET: system clock and sync active-high reset
// SCLK/MOSI/nSDCS: asynchronous SPI inputs; MISO/MISO_OE: serial reply and drive enable
// RX_DATA/RX_STROBE: last received byte; CMD_*: decoded 6-byte command frame
// RSP_DATA/RSP_VALID/RSP_READY: single-entry reply holding register
// FRAME_ERR/OVERRUN: error pulses
module sd_spi_responder
    import spi_sd_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic        CLKX4,
    input  logic        RESET,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        nSDCS,
    output logic        MISO,
    output logic        MISO_OE,
    output logic [7:0]  RX_DATA,
    output logic        RX_STROBE,
    output logic        CMD_VALID,
    output logic [5:0]  CMD_INDEX,
    output logic [31:0] CMD_ARG,
    output logic [6:0]  CMD_CRC,
    input  logic        CMD_ACK,
    input  logic [7:0]  RSP_DATA,
    input  logic        RSP_VALID,
    output logic        RSP_READY,
    output logic        FRAME_ERR,
    output logic        OVERRUN
);
    localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

    logic         w_sclk, w_mosi, w_ncs, w_rise, w_fall, w_byte_done, w_tx_load;
    logic [7:0]   w_byte;
    logic         r_sclk_d, r_ncs_d, r_hold_full;
    logic [2:0]   r_bitcnt, r_bytecnt;
    logic [6:0]   r_shift;
    logic [7:0]   r_tx, r_hold;
    logic [37:0]  r_frame;
    frame_state_t r_state;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.i_clk(CLKX4), .i_rst(RESET), .i_d(SCLK),  .o_q(w_sclk));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mosi (.i_clk(CLKX4), .i_rst(RESET), .i_d(MOSI),  .o_q(w_mosi));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs  (.i_clk(CLKX4), .i_rst(RESET), .i_d(nSDCS), .o_q(w_ncs));

    assign w_rise      = w_sclk & ~r_sclk_d;
    assign w_fall      = ~w_sclk & r_sclk_d;
    assign w_byte      = {r_shift, w_mosi};
    assign w_byte_done = w_rise & ~w_ncs & (r_bitcnt == 3'd7);
    assign w_tx_load   = w_byte_done | (~w_ncs & r_ncs_d);
    assign MISO_OE     = ~w_ncs;
    assign MISO        = w_ncs | r_tx[7];
    assign RSP_READY   = ~r_hold_full;

    always_ff @(posedge CLKX4) begin
        if (RESET) begin
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b1;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            RX_DATA     <= '0;
            RX_STROBE   <= 1'b0;
            r_tx        <= IDLE_BYTE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_sclk_d  <= w_sclk;
            r_ncs_d   <= w_ncs;
            RX_STROBE <= w_byte_done;
            if (w_ncs) begin
                r_bitcnt <= '0;
                r_shift  <= '0;
            end else if (w_rise) begin
                r_bitcnt <= r_bitcnt + 3'd1;
                r_shift  <= w_byte[6:0];
            end
            if (w_byte_done)
                RX_DATA <= w_byte;
            // The fall right after a byte boundary must not shift: the freshly
            // loaded bit 7 is what the master samples on the next rise.
            if (w_tx_load)
                r_tx <= r_hold_full ? r_hold : IDLE_BYTE;
            else if (w_fall && !w_ncs && r_bitcnt != 3'd0)
                r_tx <= {r_tx[6:0], 1'b1};
            // Load into the transmitter sees the old holding contents; a new
            // offer in the same cycle then refills the holding register.
            if (w_tx_load)
                r_hold_full <= 1'b0;
            if (RSP_VALID && !r_hold_full) begin
                r_hold      <= RSP_DATA;
                r_hold_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLKX4) begin
        if (RESET) begin
            r_state   <= HUNT;
            r_bytecnt <= '0;
            r_frame   <= '0;
            CMD_VALID <= 1'b0;
            CMD_INDEX <= '0;
            CMD_ARG   <= '0;
            CMD_CRC   <= '0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
            if (w_byte_done)
                r_frame <= {r_frame[29:0], w_byte};
            case (r_state)
                HUNT:
                    if (w_byte_done && is_start(w_byte)) begin
                        r_state   <= COLLECT;
                        r_bytecnt <= 3'd1;
                    end
                COLLECT:
                    if (w_ncs)
                        r_state <= HUNT;
                    else if (w_byte_done) begin
                        r_bytecnt <= r_bytecnt + 3'd1;
                        if (r_bytecnt == LAST_BYTE) begin
                            if (w_byte[0]) begin
                                r_state   <= PENDING;
                                CMD_VALID <= 1'b1;
                                CMD_INDEX <= r_frame[37:32];
                                CMD_ARG   <= r_frame[31:0];
                                CMD_CRC   <= w_byte[7:1];
                            end else begin
                                r_state   <= HUNT;
                                FRAME_ERR <= 1'b1;
                            end
                        end
                    end
                PENDING:
                    if (CMD_ACK) begin
                        r_state   <= HUNT;
                        CMD_VALID <= 1'b0;
                    end else if (w_byte_done && is_start(w_byte))
                        OVERRUN <= 1'b1;
                default:
                    r_state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_spi_responder.sv
// tb_sd_spi_responder: directed and randomized checks of sd_spi_responder against a frame-level model
module tb_sd_spi_responder;
    logic        CLKX4 = 1'b0, RESET = 1'b1, SCLK = 1'b0, MOSI = 1'b1, nSDCS = 1'b1;
    logic        CMD_ACK = 1'b0, RSP_VALID = 1'b0;
    logic [7:0]  RSP_DATA = 8'h00;
    logic        MISO, MISO_OE, RX_STROBE, CMD_VALID, RSP_READY, FRAME_ERR, OVERRUN;
    logic [7:0]  RX_DATA;
    logic [5:0]  CMD_INDEX;
    logic [31:0] CMD_ARG;
    logic [6:0]  CMD_CRC;

    sd_spi_responder dut (
        .CLKX4(CLKX4), .RESET(RESET), .SCLK(SCLK), .MOSI(MOSI), .nSDCS(nSDCS),
        .MISO(MISO), .MISO_OE(MISO_OE), .RX_DATA(RX_DATA), .RX_STROBE(RX_STROBE),
        .CMD_VALID(CMD_VALID), .CMD_INDEX(CMD_INDEX), .CMD_ARG(CMD_ARG), .CMD_CRC(CMD_CRC),
        .CMD_ACK(CMD_ACK), .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
    );

    always #5 CLKX4 = ~CLKX4;

    int n_cmp = 0, n_err = 0, fe_cnt = 0, ov_cnt = 0, st_cnt = 0;
    logic [7:0] rxq[$];

    always @(negedge CLKX4) begin
        if (FRAME_ERR) fe_cnt++;
        if (OVERRUN)   ov_cnt++;
        if (RX_STROBE) st_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string t);
        check({t, "_valid"}, CMD_VALID, 0);
        check({t, "_strobe"}, RX_STROBE, 0);
        check({t, "_ferr"}, FRAME_ERR, 0);
        check({t, "_ovr"}, OVERRUN, 0);
        check({t, "_ready"}, RSP_READY, 1);
        check({t, "_miso"}, MISO, 1);
        check({t, "_oe"}, MISO_OE, 0);
        check({t, "_rxdata"}, RX_DATA, 0);
        check({t, "_index"}, CMD_INDEX, 0);
        check({t, "_arg"}, CMD_ARG, 0);
        check({t, "_crc"}, CMD_CRC, 0);
    endtask

    // Mode 0 master: MOSI set in the low phase, both lines sampled at the rise.
    task automatic spi_byte(input logic [7:0] tx, input logic ld, input logic [7:0] rsp);
        logic [7:0] rx;
        for (int i = 7; i >= 0; i--) begin
            MOSI = tx[i];
            if (ld && i == 4) begin
                RSP_DATA = rsp; RSP_VALID = 1'b1; #10; RSP_VALID = 1'b0; #50;
            end else #60;
            rx[i] = MISO;
            SCLK = 1'b1; #60; SCLK = 1'b0;
        end
        rxq.push_back(rx);
    endtask

    task automatic frame(input logic [47:0] f);
        for (int i = 5; i >= 0; i--) spi_byte(f[i*8 +: 8], 1'b0, 8'h00);
    endtask

    task automatic cs_on;  rxq.delete(); nSDCS = 1'b0; #80; endtask
    task automatic cs_off; #60; nSDCS = 1'b1; #100; endtask

    task automatic ack;
        @(negedge CLKX4) CMD_ACK = 1'b1;
        @(negedge CLKX4) CMD_ACK = 1'b0;
    endtask

    function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc, input logic stop);
        return {2'b01, idx, arg, crc, stop};
    endfunction

    task automatic check_cmd(input string t, input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc);
        check({t, "_valid"}, CMD_VALID, 1);
        check({t, "_index"}, CMD_INDEX, idx);
        check({t, "_arg"}, CMD_ARG, arg);
        check({t, "_crc"}, CMD_CRC, crc);
    endtask

    initial begin
        int fe0, ov0, st0, nov;
        logic [5:0] idx, idx_a;
        logic [31:0] arg, arg_a;
        logic [6:0] crc, crc_a;
        logic stop, pre;
        logic [7:0] rsp;
        logic [47:0] f;

        repeat (5) @(negedge CLKX4);
        check_reset("rst");
        RESET = 1'b0;
        repeat (4) @(negedge CLKX4);

        // CMD0
        st0 = st_cnt;
        cs_on();
        frame(48'h40_00_00_00_00_95);
        check("cmd0_oe", MISO_OE, 1);
        cs_off();
        check_cmd("cmd0", 6'd0, 32'd0, 7'h4A);
        check("cmd0_rxdata", RX_DATA, 8'h95);
        check("cmd0_strobes", st_cnt - st0, 6);
        for (int i = 0; i < 6; i++) check($sformatf("cmd0_miso%0d", i), rxq[i], 8'hFF);
        ack();
        check("cmd0_ack", CMD_VALID, 0);

        // CMD17 with a reply byte offered during byte 6
        cs_on();
        spi_byte(8'h51, 0, 0); spi_byte(8'h00, 0, 0); spi_byte(8'h00, 0, 0);
        spi_byte(8'h02, 0, 0); spi_byte(8'h00, 0, 0); spi_byte(8'hFF, 1, 8'h00);
        spi_byte(8'hFF, 0, 0); spi_byte(8'hFF, 0, 0);
        cs_off();
        check_cmd("cmd17", 6'd17, 32'h0000_0200, 7'h7F);
        check("cmd17_b6", rxq[5], 8'hFF);
        check("cmd17_b7", rxq[6], 8'h00);
        check("cmd17_b8", rxq[7], 8'hFF);
        check("cmd17_ready", RSP_READY, 1);
        ack();

        // bad stop bit, then a random good frame
        fe0 = fe_cnt;
        cs_on(); frame(48'h48_00_00_01_AA_86); cs_off();
        check("badstop_ferr", fe_cnt - fe0, 1);
        check("badstop_valid", CMD_VALID, 0);
        idx = 6'($urandom); arg = $urandom; crc = 7'($urandom);
        cs_on(); frame(mk(idx, arg, crc, 1'b1)); cs_off();
        check_cmd("afterbad", idx, arg, crc);
        ack();

        // card select dropped mid-frame
        fe0 = fe_cnt;
        cs_on();
        spi_byte(8'h4C, 0, 0); spi_byte(8'($urandom), 0, 0); spi_byte(8'($urandom), 0, 0);
        cs_off();
        check("abort_ferr", fe_cnt - fe0, 0);
        check("abort_valid", CMD_VALID, 0);
        cs_on(); frame(48'h40_00_00_00_00_95); cs_off();
        check_cmd("abort_next", 6'd0, 32'd0, 7'h4A);
        ack();

        // second frame while the first is pending
        idx_a = 6'($urandom); arg_a = $urandom; crc_a = 7'($urandom);
        cs_on(); frame(mk(idx_a, arg_a, crc_a, 1'b1)); cs_off();
        ov0 = ov_cnt;
        f = mk(6'($urandom), $urandom, 7'($urandom), 1'b1);
        nov = 0;
        for (int i = 0; i < 6; i++) if (f[i*8+6 +: 2] == 2'b01) nov++;
        cs_on(); frame(f); cs_off();
        check("ovr_count", ov_cnt - ov0, nov);
        check_cmd("ovr_hold", idx_a, arg_a, crc_a);
        ack();

        // reset after four frame bytes
        fe0 = fe_cnt;
        cs_on();
        spi_byte(8'h40, 0, 0); spi_byte(8'h00, 0, 0); spi_byte(8'h00, 0, 0); spi_byte(8'h00, 0, 0);
        @(negedge CLKX4) RESET = 1'b1;
        repeat (3) @(negedge CLKX4);
        check_reset("midrst");
        RESET = 1'b0;
        #80;
        spi_byte(8'h00, 0, 0); spi_byte(8'h95, 0, 0);
        cs_off();
        check("midrst_valid", CMD_VALID, 0);
        check("midrst_ferr", fe_cnt - fe0, 0);

        // randomized frames with optional reply byte preloaded before select
        for (int n = 0; n < 8; n++) begin
            idx = 6'($urandom); arg = $urandom; crc = 7'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            pre = 1'($urandom_range(0, 1));
            rsp = 8'($urandom);
            fe0 = fe_cnt;
            if (pre) begin
                @(negedge CLKX4) begin RSP_DATA = rsp; RSP_VALID = 1'b1; end
                @(negedge CLKX4) RSP_VALID = 1'b0;
                check($sformatf("rnd%0d_busy", n), RSP_READY, 0);
            end
            cs_on(); frame(mk(idx, arg, crc, stop)); cs_off();
            check($sformatf("rnd%0d_miso0", n), rxq[0], pre ? rsp : 8'hFF);
            check($sformatf("rnd%0d_miso5", n), rxq[5], 8'hFF);
            check($sformatf("rnd%0d_ready", n), RSP_READY, 1);
            check($sformatf("rnd%0d_rxdata", n), RX_DATA, {crc, stop});
            check($sformatf("rnd%0d_valid", n), CMD_VALID, stop);
            check($sformatf("rnd%0d_ferr", n), fe_cnt - fe0, stop ? 0 : 1);
            if (stop) begin
                check($sformatf("rnd%0d_index", n), CMD_INDEX, idx);
                check($sformatf("rnd%0d_arg", n), CMD_ARG, arg);
                check($sformatf("rnd%0d_crc", n), CMD_CRC, crc);
                ack();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
